fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter: DW, 8, data width in bits.
REQ-002 Parameter: AW, 4, storage address width; depth = 2^AW = 16 entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_req0 / wr_req1  input  1 each  write request from producer 0 / 1.
REQ-006 wr_data0 / wr_data1  input  DW each  write data from producer 0 / 1.
REQ-007 wr_gnt0 / wr_gnt1  output  1 each  combinational grant; the write is performed at the same edge.
REQ-008 rd_req  input  1  consumer read request.
REQ-009 rd_valid  output  1  registered; high the cycle after an accepted read, aligned with storage read data.
REQ-010 flush  input  1  discard all contents.
REQ-011 mem_we, mem_waddr[AW-1:0], mem_wdata[DW-1:0]  output  storage write port.
REQ-012 mem_re, mem_raddr[AW-1:0]  output  storage read port; storage returns data one cycle after mem_re.
REQ-013 full, empty  output  1 each  occupancy flags.
REQ-014 count  output  AW+1  entries held, 0..16.
REQ-015 ovf_err, udf_err  output  1 each  sticky overflow / underflow flags.

Function
REQ-016 Two AW+1-bit pointers (wr_ptr, rd_ptr) shall be kept; the low AW bits are the address and the MSB toggles on wrap from 15 to 0.
REQ-017 empty = (wr_ptr == rd_ptr); full = low bits equal and MSBs differ; count = (wr_ptr - rd_ptr) mod 2^(AW+1).
REQ-018 A write shall be accepted only in state RUN, when not full and at least one wr_req is high.
REQ-019 Single requester: it is granted; both requesting: grant goes to the requester not granted last (round-robin via last_gnt register).
REQ-020 At most one grant per cycle; a losing requester holds wr_req and data until granted.
REQ-021 On accept: mem_we=1, mem_waddr=wr_ptr[AW-1:0], mem_wdata=granted producer's data, wr_ptr increments, last_gnt updates.
REQ-022 A read shall be accepted only in state RUN, when rd_req=1 and not empty: mem_re=1, mem_raddr=rd_ptr[AW-1:0], rd_ptr increments, rd_valid=1 next cycle.
REQ-023 Full/empty shall be evaluated on current-cycle state only: a write is refused when full even if a read is accepted in the same cycle; a read is refused when empty even if a write is accepted (no bypass).
REQ-024 Simultaneous accepted read and write shall leave count unchanged.
REQ-025 Any wr_req high while full (RUN) shall set ovf_err; rd_req high while empty (RUN) shall set udf_err; both remain set until reset or flush.
REQ-026 FSM states RUN and FLUSH; RUN -> FLUSH when flush=1; FLUSH -> RUN unconditionally after one cycle.
REQ-027 In FLUSH: no grants, mem_we=0, mem_re=0, both pointers cleared to 0, ovf_err/udf_err cleared, last_gnt unchanged.
REQ-028 A read accepted in the cycle flush is sampled shall still produce rd_valid the next cycle.
REQ-029 mem_we, mem_re and grants shall be 0 whenever not accepting.

Reset
REQ-030 With reset=1 at a rising edge: wr_ptr=rd_ptr=0, state=RUN, rd_valid=0, ovf_err=udf_err=0, last_gnt=producer 1 (so producer 0 wins the first tie).
REQ-031 After reset: empty=1, full=0, count=0, all grants, mem_we and mem_re 0.
REQ-032 reset shall take priority over flush and over any request in the same cycle; reset mid-traffic discards all contents.

Verification
REQ-033 Reset, then wr_req0=1 with data 0x11..0x20 for 16 cycles -> 16 grants, mem_waddr 0..15, full=1, count=16; 17th request -> no grant, ovf_err=1.
REQ-034 Both producers request continuously from empty -> grants alternate 0,1,0,1; first grant to producer 0.
REQ-035 Fill 16, then rd_req 16 cycles -> mem_raddr 0..15, rd_valid each following cycle, empty=1; next rd_req -> no mem_re, udf_err=1.
REQ-036 count=8, simultaneous write and read for 20 cycles -> count stays 8, pointers wrap past 15 to 0 with MSB toggle.
REQ-037 count=5, flush=1 one cycle -> next cycle no grants, then count=0, empty=1, sticky flags cleared, RUN resumes.
REQ-038 Reset asserted with flush=1 and both wr_req high at count=10 -> count=0, no grant, state RUN, rd_valid=0.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: two-producer round-robin FIFO controller driving an external synchronous storage
module fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req0,
  input  logic          wr_req1,
  input  logic [DW-1:0] wr_data0,
  input  logic [DW-1:0] wr_data1,
  output logic          wr_gnt0,
  output logic          wr_gnt1,
  input  logic          rd_req,
  output logic          rd_valid,
  input  logic          flush,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf_err,
  output logic          udf_err
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [AW:0] wr_ptr, rd_ptr;
  logic last_gnt, run, any_wr, pick1, wr_ok, rd_ok;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;
  assign run = (state == RUN) && !reset;
  assign any_wr = wr_req0 | wr_req1;
  assign pick1 = wr_req1 & (~wr_req0 | ~last_gnt);
  assign wr_ok = run & ~full & any_wr;
  assign rd_ok = run & rd_req & ~empty;
  assign wr_gnt0 = wr_ok & ~pick1;
  assign wr_gnt1 = wr_ok & pick1;
  assign mem_we = wr_ok;
  assign mem_waddr = wr_ptr[AW-1:0];
  assign mem_wdata = pick1 ? wr_data1 : wr_data0;
  assign mem_re = rd_ok;
  assign mem_raddr = rd_ptr[AW-1:0];
  // next state: a flush seen in RUN buys exactly one FLUSH cycle
  always_comb begin
    state_nx = (state == RUN && flush) ? FLUSH : RUN;
  end
  // pointers, arbitration history, read-valid pipe and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_valid <= 1'b0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nx;
      rd_valid <= rd_ok;
      if (state == FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf_err <= 1'b0;
        udf_err <= 1'b0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (wr_ok) last_gnt <= pick1;
        if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        ovf_err <= ovf_err | (full & any_wr);
        udf_err <= udf_err | (empty & rd_req);
      end
    end
  end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: queue-based reference model checking fifo_ctrl under directed and random traffic
module tb_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wr_req0 = 1'b0, wr_req1 = 1'b0, rd_req = 1'b0, flush = 1'b0;
  logic [DW-1:0] wr_data0 = '0, wr_data1 = '0;
  logic wr_gnt0, wr_gnt1, rd_valid, mem_we, mem_re, full, empty, ovf_err, udf_err;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0] count;
  fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .wr_req0(wr_req0), .wr_req1(wr_req1), .wr_data0(wr_data0), .wr_data1(wr_data1),
    .wr_gnt0(wr_gnt0), .wr_gnt1(wr_gnt1),
    .rd_req(rd_req), .rd_valid(rd_valid), .flush(flush),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr),
    .full(full), .empty(empty), .count(count), .ovf_err(ovf_err), .udf_err(udf_err)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] mem [D];
  logic [DW-1:0] rdata;
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) rdata <= mem[mem_raddr];
  end
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_data, d0, d1;
  int wr_n, rd_n, last, ovf, udf, flushing, exp_valid;
  bit pend0, pend1;
  task automatic model_clear();
    q.delete();
    wr_n = 0;
    rd_n = 0;
    ovf = 0;
    udf = 0;
    flushing = 0;
    exp_valid = 0;
  endtask
  task automatic step();
    int g;
    bit any, rd_ok;
    #1;
    chk("rd_valid", rd_valid, exp_valid);
    if (exp_valid != 0) chk("rd_data", rdata, exp_data);
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == D);
    chk("ovf_err", ovf_err, ovf);
    chk("udf_err", udf_err, udf);
    any = wr_req0 | wr_req1;
    g = -1;
    if (!reset && flushing == 0 && q.size() < D && any)
      g = (wr_req0 && wr_req1) ? 1 - last : (wr_req0 ? 0 : 1);
    rd_ok = !reset && flushing == 0 && rd_req && q.size() > 0;
    chk("wr_gnt0", wr_gnt0, g == 0);
    chk("wr_gnt1", wr_gnt1, g == 1);
    chk("mem_we", mem_we, g >= 0);
    if (g >= 0) begin
      chk("mem_waddr", mem_waddr, wr_n % D);
      chk("mem_wdata", mem_wdata, g == 1 ? wr_data1 : wr_data0);
    end
    chk("mem_re", mem_re, rd_ok);
    if (rd_ok) chk("mem_raddr", mem_raddr, rd_n % D);
    if (reset) begin
      model_clear();
      last = 1;
    end else if (flushing != 0) begin
      model_clear();
    end else begin
      if (any && q.size() == D) ovf = 1;
      if (rd_req && q.size() == 0) udf = 1;
      exp_valid = rd_ok;
      if (rd_ok) begin
        exp_data = q.pop_front();
        rd_n++;
      end
      if (g >= 0) begin
        q.push_back(g == 1 ? wr_data1 : wr_data0);
        wr_n++;
        last = g;
      end
      flushing = flush;
    end
    if (g == 0) pend0 = 0;
    if (g == 1) pend1 = 0;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set(bit r0, bit r1, bit rr, bit fl);
    if (!pend0 && r0) d0 = DW'($urandom);
    if (!pend1 && r1) d1 = DW'($urandom);
    pend0 = pend0 | r0;
    pend1 = pend1 | r1;
    wr_req0 = pend0;
    wr_req1 = pend1;
    wr_data0 = pend0 ? d0 : DW'($urandom);
    wr_data1 = pend1 ? d1 : DW'($urandom);
    rd_req = rr;
    flush = fl;
  endtask
  task automatic run(int n, bit r0, bit r1, bit rr, bit fl);
    for (int i = 0; i < n; i++) begin
      set(r0, r1, rr, fl);
      step();
    end
  endtask
  task automatic drop();
    pend0 = 0;
    pend1 = 0;
  endtask
  initial begin
    pend0 = 0;
    pend1 = 0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_clear();
    last = 1;
    run(1, 1, 1, 1, 1);
    reset = 1'b0;
    drop();
    run(17, 1, 0, 0, 0);
    drop();
    run(17, 0, 0, 1, 0);
    run(8, 1, 1, 0, 0);
    drop();
    run(8, 0, 0, 1, 0);
    run(8, 1, 0, 0, 0);
    drop();
    run(20, 1, 0, 1, 0);
    drop();
    run(3, 0, 0, 1, 0);
    run(1, 0, 0, 1, 1);
    run(1, 1, 1, 0, 0);
    drop();
    run(3, 0, 0, 1, 0);
    for (int p = 0; p < 4; p++) begin
      int pw, pr;
      pw = (p == 0) ? 70 : (p == 1) ? 30 : (p == 2) ? 60 : 50;
      pr = (p == 0) ? 30 : (p == 1) ? 70 : (p == 2) ? 60 : 50;
      for (int i = 0; i < 300; i++) begin
        set($urandom_range(99) < pw, $urandom_range(99) < pw,
            $urandom_range(99) < pr, $urandom_range(99) < 2);
        step();
      end
    end
    drop();
    run(2, 0, 0, 0, 1);
    run(10, 1, 0, 0, 0);
    drop();
    reset = 1'b1;
    run(1, 1, 1, 1, 1);
    reset = 1'b0;
    drop();
    run(2, 0, 0, 0, 0);
    run(4, 1, 1, 1, 0);
    drop();
    run(4, 0, 0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
